// File: rtl/conv_pkg.sv
// Purpose: shared types and constants for the convolution tile scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package conv_pkg;

    // Scheduler control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Fetch command encodings. They tell the shift-register window how to
    // move for the current kernel step.
    localparam logic [1:0] FT_FULL = 2'd0;  // load a whole tile (first step)
    localparam logic [1:0] FT_COL  = 2'd1;  // shift one column (first kernel row)
    localparam logic [1:0] FT_ROW  = 2'd2;  // advance one row (start of a kernel row)
    localparam logic [1:0] FT_ELEM = 2'd3;  // single element (everything else)

    localparam int KERNEL_SIZE_MAX = 5;

    // Number of WAIT cycles without a result strobe before the watchdog trips.
    localparam int TIMEOUT_LIMIT = 64;

endpackage

// File: rtl/conv_kernel_walker.sv
// Purpose: walks the k x k kernel positions (column first), decoding the fetch type and weight address.
// Latency: registered; values for step c are visible the cycle after load/advance selects step c.
// Backpressure: none; steps once per cycle while advance is high, wraps to step 0 after the last step.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   ksize         kernel size k (already latched by the scheduler)
//   load          force step 0 (start of a tile)
//   advance       move to the next step
//   krow, kcol    current kernel position
//   ftype         fetch type for the current step
//   waddr         row-major weight index krow*k + kcol
//   last          current step is (k-1, k-1)
module conv_kernel_walker
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE_WIDTH = 3,
    parameter int WADDR_WIDTH       = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [KERNEL_SIZE_WIDTH-1:0] ksize,
    input  logic                         load,
    input  logic                         advance,
    output logic [KERNEL_SIZE_WIDTH-1:0] krow,
    output logic [KERNEL_SIZE_WIDTH-1:0] kcol,
    output logic [1:0]                   ftype,
    output logic [WADDR_WIDTH-1:0]       waddr,
    output logic                         last
);

    logic [KERNEL_SIZE_WIDTH-1:0] km1;
    logic [KERNEL_SIZE_WIDTH-1:0] nrow;
    logic [KERNEL_SIZE_WIDTH-1:0] ncol;
    logic [1:0]                   ntype;
    logic [WADDR_WIDTH-1:0]       naddr;

    assign km1  = ksize - KERNEL_SIZE_WIDTH'(1);
    assign last = (krow == km1) && (kcol == km1);

    // Next position and its decoded outputs are computed here so that the
    // type and address are registered together with the counters.
    always_comb begin
        nrow = krow;
        ncol = kcol;
        if (load || last) begin
            nrow = '0;
            ncol = '0;
        end else if (kcol == km1) begin
            ncol = '0;
            nrow = krow + KERNEL_SIZE_WIDTH'(1);
        end else begin
            ncol = kcol + KERNEL_SIZE_WIDTH'(1);
        end

        // kcol==0 is the c%k==0 case; krow==0 with kcol>0 is 0<c<k.
        if ((nrow == '0) && (ncol == '0)) begin
            ntype = FT_FULL;
        end else if (ncol == '0) begin
            ntype = FT_ROW;
        end else if (nrow == '0) begin
            ntype = FT_COL;
        end else begin
            ntype = FT_ELEM;
        end

        naddr = WADDR_WIDTH'(nrow) * WADDR_WIDTH'(ksize) + WADDR_WIDTH'(ncol);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            krow  <= '0;
            kcol  <= '0;
            ftype <= FT_FULL;
            waddr <= '0;
        end else if (load || advance) begin
            krow  <= nrow;
            kcol  <= ncol;
            ftype <= ntype;
            waddr <= naddr;
        end
    end

endmodule

// File: rtl/conv_tile_scheduler.sv
// Purpose: per-tile sequencer for the float16 MAC array: reset datapath, feed k*k fetch steps, capture result, hand off downstream.
// Latency: start at T -> fetch T+1..T+k*k; result strobe at W -> out_valid W+1; accept at H -> next feed at H+2, done at H+1.
// Backpressure: out_valid/out_ready; while out_ready is low the result is held and no new tile is fed.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset (aborts any job)
//   start, kernel_size,      job start (IDLE only), k in {3,5}, tile count (0 means 1)
//   num_tiles
//   busy, err_ksize          not-IDLE flag, one-cycle illegal kernel size pulse
//   conv_rst_n               active-low datapath reset
//   fetch_valid, fetch_type, fetch command per kernel step
//   fetch_krow, fetch_kcol,
//   weight_addr
//   conv_result_ready,       datapath result strobe and data
//   conv_result
//   out_valid, out_ready,    downstream handshake with held result and tile index
//   out_data, out_tile
//   done                     one-cycle pulse after the last tile is accepted
//   err_timeout              sticky watchdog flag; only active when CONV_SCHED_TIMEOUT_EN is defined
module conv_tile_scheduler
    import conv_pkg::*;
#(
    parameter int PARA_X            = 3,
    parameter int PARA_Y            = 3,
    parameter int DATA_WIDTH        = 16,
    parameter int KERNEL_SIZE_WIDTH = 3,
    parameter int TILE_CNT_WIDTH    = 8,
    parameter int WADDR_WIDTH       = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [KERNEL_SIZE_WIDTH-1:0]        kernel_size,
    input  logic [TILE_CNT_WIDTH-1:0]           num_tiles,
    output logic                                busy,
    output logic                                err_ksize,
    output logic                                conv_rst_n,
    output logic                                fetch_valid,
    output logic [1:0]                          fetch_type,
    output logic [KERNEL_SIZE_WIDTH-1:0]        fetch_krow,
    output logic [KERNEL_SIZE_WIDTH-1:0]        fetch_kcol,
    output logic [WADDR_WIDTH-1:0]              weight_addr,
    input  logic                                conv_result_ready,
    input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0] conv_result,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [PARA_X*PARA_Y*DATA_WIDTH-1:0] out_data,
    output logic [TILE_CNT_WIDTH-1:0]           out_tile,
    output logic                                done,
    output logic                                err_timeout
);

    state_t                       state;
    logic [KERNEL_SIZE_WIDTH-1:0] k_q;
    logic [TILE_CNT_WIDTH-1:0]    last_tile;
    logic [TILE_CNT_WIDTH-1:0]    tile_idx;
    logic                         ksize_ok;
    logic                         walk_load;
    logic                         walk_adv;
    logic                         walk_last;

`ifdef CONV_SCHED_TIMEOUT_EN
    logic [6:0]                   wait_cnt;
`else
    assign err_timeout = 1'b0;
`endif

    assign ksize_ok = (kernel_size == KERNEL_SIZE_WIDTH'(3)) ||
                      (kernel_size == KERNEL_SIZE_WIDTH'(5));

    // Walker restarts at step 0 whenever a tile's feed is about to begin:
    // on a legal start, and on the gap cycle in HOLD after an acceptance
    // (out_valid already low there).
    assign walk_load = ((state == ST_IDLE) && start && ksize_ok) ||
                       ((state == ST_HOLD) && !out_valid);
    assign walk_adv  = (state == ST_FEED);

    conv_kernel_walker #(
        .KERNEL_SIZE_WIDTH (KERNEL_SIZE_WIDTH),
        .WADDR_WIDTH       (WADDR_WIDTH)
    ) u_walker (
        .clk     (clk),
        .rst     (rst),
        .ksize   (k_q),
        .load    (walk_load),
        .advance (walk_adv),
        .krow    (fetch_krow),
        .kcol    (fetch_kcol),
        .ftype   (fetch_type),
        .waddr   (weight_addr),
        .last    (walk_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            err_ksize   <= 1'b0;
            conv_rst_n  <= 1'b0;
            fetch_valid <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_tile    <= '0;
            done        <= 1'b0;
            k_q         <= '0;
            last_tile   <= '0;
            tile_idx    <= '0;
`ifdef CONV_SCHED_TIMEOUT_EN
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
`endif
        end else begin
            done      <= 1'b0;
            err_ksize <= 1'b0;
            case (state)
                ST_IDLE: begin
                    conv_rst_n  <= 1'b0;
                    fetch_valid <= 1'b0;
                    if (start) begin
                        if (ksize_ok) begin
                            k_q         <= kernel_size;
                            last_tile   <= (num_tiles == '0) ? '0
                                                             : num_tiles - TILE_CNT_WIDTH'(1);
                            tile_idx    <= '0;
                            busy        <= 1'b1;
                            conv_rst_n  <= 1'b1;
                            fetch_valid <= 1'b1;
                            state       <= ST_FEED;
                        end else begin
                            err_ksize <= 1'b1;
                        end
                    end
                end

                // A result strobe here is deliberately ignored.
                ST_FEED: begin
                    if (walk_last) begin
                        fetch_valid <= 1'b0;
                        state       <= ST_WAIT;
`ifdef CONV_SCHED_TIMEOUT_EN
                        wait_cnt    <= '0;
`endif
                    end
                end

                ST_WAIT: begin
                    if (conv_result_ready) begin
                        out_data   <= conv_result;
                        out_tile   <= tile_idx;
                        out_valid  <= 1'b1;
                        conv_rst_n <= 1'b0;
                        state      <= ST_HOLD;
                    end
`ifdef CONV_SCHED_TIMEOUT_EN
                    else if (wait_cnt == 7'(TIMEOUT_LIMIT - 1)) begin
                        err_timeout <= 1'b1;
                        conv_rst_n  <= 1'b0;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 7'd1;
                    end
`endif
                end

                // HOLD covers two phases: holding the result (out_valid high)
                // and one gap cycle after acceptance that keeps the datapath
                // in reset before the next tile's feed.
                ST_HOLD: begin
                    if (out_valid) begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            if (tile_idx == last_tile) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end
                        end
                    end else begin
                        tile_idx    <= tile_idx + TILE_CNT_WIDTH'(1);
                        conv_rst_n  <= 1'b1;
                        fetch_valid <= 1'b1;
                        state       <= ST_FEED;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Purpose: randomized self-checking bench for conv_tile_scheduler against a cycle-timing reference model.
// Latency: n/a.
// Backpressure: out_ready stalls are randomized and directed.
module tb_conv_tile_scheduler;

    localparam int PX = 3;
    localparam int PY = 3;
    localparam int DW = 16;
    localparam int KW = 3;
    localparam int TW = 8;
    localparam int WW = 5;
    localparam int OW = PX * PY * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [KW-1:0] kernel_size;
    logic [TW-1:0] num_tiles;
    logic          busy;
    logic          err_ksize;
    logic          conv_rst_n;
    logic          fetch_valid;
    logic [1:0]    fetch_type;
    logic [KW-1:0] fetch_krow;
    logic [KW-1:0] fetch_kcol;
    logic [WW-1:0] weight_addr;
    logic          conv_result_ready;
    logic [OW-1:0] conv_result;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic [TW-1:0] out_tile;
    logic          done;
    logic          err_timeout;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    conv_tile_scheduler #(
        .PARA_X            (PX),
        .PARA_Y            (PY),
        .DATA_WIDTH        (DW),
        .KERNEL_SIZE_WIDTH (KW),
        .TILE_CNT_WIDTH    (TW),
        .WADDR_WIDTH       (WW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .kernel_size       (kernel_size),
        .num_tiles         (num_tiles),
        .busy              (busy),
        .err_ksize         (err_ksize),
        .conv_rst_n        (conv_rst_n),
        .fetch_valid       (fetch_valid),
        .fetch_type        (fetch_type),
        .fetch_krow        (fetch_krow),
        .fetch_kcol        (fetch_kcol),
        .weight_addr       (weight_addr),
        .conv_result_ready (conv_result_ready),
        .conv_result       (conv_result),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_tile          (out_tile),
        .done              (done),
        .err_timeout       (err_timeout)
    );

    task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Fetch type of step c for kernel size k, straight from the step rules.
    function automatic int exp_type(input int c, input int k);
        if (c == 0)     return 0;
        if (c % k == 0) return 2;
        if (c < k)      return 1;
        return 3;
    endfunction

    function automatic logic [OW-1:0] rand_data();
        logic [OW-1:0] d;
        for (int i = 0; i < PX * PY; i++) d[i*DW +: DW] = DW'($urandom);
        return d;
    endfunction

    // One job: inputs change on the falling edge, outputs are checked there.
    task automatic run_job(input int k, input int n, input bit hold_rdy, input int stall_fix,
                           input bit strobe_early, input bit start_in_feed);
        int            ntl;
        int            lat;
        int            stall;
        logic [OW-1:0] d;
        ntl         = (n == 0) ? 1 : n;
        kernel_size = KW'(k);
        num_tiles   = TW'(n);
        out_ready   = hold_rdy;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < ntl; t++) begin
            for (int c = 0; c < k * k; c++) begin
                check("feed_vld",   OW'(fetch_valid), OW'(1));
                check("feed_crst",  OW'(conv_rst_n),  OW'(1));
                check("feed_busy",  OW'(busy),        OW'(1));
                check("feed_type",  OW'(fetch_type),  OW'(exp_type(c, k)));
                check("feed_krow",  OW'(fetch_krow),  OW'(c / k));
                check("feed_kcol",  OW'(fetch_kcol),  OW'(c % k));
                check("feed_waddr", OW'(weight_addr), OW'(c));
                check("feed_noerr", OW'(err_ksize),   OW'(0));
                check("feed_oval",  OW'(out_valid),   OW'(0));
                if (start_in_feed && t == 0 && c == 1) begin
                    kernel_size = KW'(4);
                    start       = 1'b1;
                end
                if (strobe_early && c == k * k - 1) begin
                    conv_result_ready = 1'b1;
                    conv_result       = rand_data();
                end
                @(negedge clk);
                start             = 1'b0;
                conv_result_ready = 1'b0;
            end
            lat = $urandom_range(0, 4);
            for (int i = 0; i < lat; i++) begin
                check("wait_fv",   OW'(fetch_valid), OW'(0));
                check("wait_crst", OW'(conv_rst_n),  OW'(1));
                check("wait_oval", OW'(out_valid),   OW'(0));
                @(negedge clk);
            end
            check("wait_fv",   OW'(fetch_valid), OW'(0));
            check("wait_oval", OW'(out_valid),   OW'(0));
            d                 = rand_data();
            conv_result       = d;
            conv_result_ready = 1'b1;
            @(negedge clk);
            conv_result_ready = 1'b0;
            conv_result       = ~d;
            check("hold_vld",  OW'(out_valid),  OW'(1));
            check("hold_data", out_data,        d);
            check("hold_tile", OW'(out_tile),   OW'(t));
            check("hold_crst", OW'(conv_rst_n), OW'(0));
            check("hold_busy", OW'(busy),       OW'(1));
            stall = hold_rdy ? 0 : ((stall_fix >= 0) ? stall_fix : $urandom_range(0, 3));
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check("stall_vld",  OW'(out_valid),   OW'(1));
                check("stall_data", out_data,         d);
                check("stall_fv",   OW'(fetch_valid), OW'(0));
                check("stall_done", OW'(done),        OW'(0));
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = hold_rdy;
            check("acc_vld",  OW'(out_valid),   OW'(0));
            check("acc_crst", OW'(conv_rst_n),  OW'(0));
            check("acc_fv",   OW'(fetch_valid), OW'(0));
            check("acc_done", OW'(done),        OW'(t == ntl - 1));
            check("acc_busy", OW'(busy),        OW'(t != ntl - 1));
            @(negedge clk);
        end
        check("idle_done", OW'(done),        OW'(0));
        check("idle_busy", OW'(busy),        OW'(0));
        check("idle_crst", OW'(conv_rst_n),  OW'(0));
        check("idle_fv",   OW'(fetch_valid), OW'(0));
        out_ready = 1'b0;
    endtask

    initial begin
        logic [OW-1:0] d;
        rst               = 1'b1;
        start             = 1'b0;
        kernel_size       = '0;
        num_tiles         = '0;
        conv_result_ready = 1'b0;
        conv_result       = '0;
        out_ready         = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_busy",  OW'(busy),        OW'(0));
        check("rst_errk",  OW'(err_ksize),   OW'(0));
        check("rst_crst",  OW'(conv_rst_n),  OW'(0));
        check("rst_fv",    OW'(fetch_valid), OW'(0));
        check("rst_type",  OW'(fetch_type),  OW'(0));
        check("rst_krow",  OW'(fetch_krow),  OW'(0));
        check("rst_kcol",  OW'(fetch_kcol),  OW'(0));
        check("rst_waddr", OW'(weight_addr), OW'(0));
        check("rst_oval",  OW'(out_valid),   OW'(0));
        check("rst_data",  out_data,         OW'(0));
        check("rst_tile",  OW'(out_tile),    OW'(0));
        check("rst_done",  OW'(done),        OW'(0));
        check("rst_tmo",   OW'(err_timeout), OW'(0));

        // Directed jobs.
        run_job(3, 1, 1'b0, -1, 1'b0, 1'b0);
        run_job(5, 2, 1'b1, -1, 1'b0, 1'b0);
        run_job(3, 2, 1'b0, 10, 1'b1, 1'b1);
        run_job(3, 0, 1'b0, -1, 1'b0, 1'b0);

        // Illegal kernel sizes.
        for (int i = 0; i < 2; i++) begin
            kernel_size = (i == 0) ? KW'(4) : KW'(7);
            start       = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("ks_err",   OW'(err_ksize),   OW'(1));
            check("ks_busy",  OW'(busy),        OW'(0));
            @(negedge clk);
            check("ks_pulse", OW'(err_ksize),   OW'(0));
            check("ks_idle",  OW'(busy),        OW'(0));
            check("ks_fv",    OW'(fetch_valid), OW'(0));
        end

        // Abort on feed step 5.
        kernel_size = KW'(5);
        num_tiles   = TW'(1);
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("ab_step", OW'(weight_addr), OW'(5));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("ab_busy", OW'(busy),        OW'(0));
        check("ab_crst", OW'(conv_rst_n),  OW'(0));
        check("ab_fv",   OW'(fetch_valid), OW'(0));
        @(negedge clk);
        check("ab_stay", OW'(fetch_valid), OW'(0));

        // Abort while a result is held: it must be discarded.
        kernel_size = KW'(3);
        num_tiles   = TW'(1);
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        d                 = rand_data();
        conv_result       = d;
        conv_result_ready = 1'b1;
        @(negedge clk);
        conv_result_ready = 1'b0;
        check("abh_vld",  OW'(out_valid), OW'(1));
        check("abh_data", out_data,       d);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abh_clr",  OW'(out_valid), OW'(0));
        check("abh_zero", out_data,       OW'(0));
        check("abh_busy", OW'(busy),      OW'(0));

        // Randomized jobs.
        for (int j = 0; j < 8; j++) begin
            run_job(($urandom_range(0, 1) == 1) ? 5 : 3, $urandom_range(0, 3),
                    $urandom_range(0, 1) == 1, -1,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

`ifdef CONV_SCHED_TIMEOUT_EN
        kernel_size = KW'(3);
        num_tiles   = TW'(1);
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            check("to_wait", OW'(err_timeout), OW'(0));
            check("to_busy", OW'(busy),        OW'(1));
            @(negedge clk);
        end
        check("to_set",  OW'(err_timeout), OW'(1));
        check("to_idle", OW'(busy),        OW'(0));
        check("to_crst", OW'(conv_rst_n),  OW'(0));
        @(negedge clk);
        check("to_stky", OW'(err_timeout), OW'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("to_clr",  OW'(err_timeout), OW'(0));
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_tile_scheduler.md
# conv_tile_scheduler

Sequencer for the parallel-scale float16 convolution datapath (PARA_X×PARA_Y MAC array with shift-register window). Per tile, it holds the datapath in reset, releases it, and drives one fetch command and one weight address per cycle for k×k cycles. It then captures the datapath result into a holding register and hands it downstream over a valid/ready handshake, repeating for a programmed number of tiles.

## Interface
- PARA_X, 3, tile rows
- PARA_Y, 3, tile columns
- DATA_WIDTH, 16, float16 word width
- KERNEL_SIZE_WIDTH, 3, kernel size field width
- TILE_CNT_WIDTH, 8, tile counter width
- WADDR_WIDTH, 5, weight address width (covers 0..24)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle job start, sampled only in IDLE
- kernel_size  in  KERNEL_SIZE_WIDTH  3 or 5, latched on start
- num_tiles  in  TILE_CNT_WIDTH  tiles in job, latched on start; 0 treated as 1
- busy  out  1  high in any state other than IDLE
- err_ksize  out  1  one-cycle pulse: start with kernel_size not 3/5
- conv_rst_n  out  1  active-low reset to datapath
- fetch_valid  out  1  fetch command valid
- fetch_type  out  2  0 full tile, 1 column shift, 2 row advance, 3 single element
- fetch_krow, fetch_kcol  out  KERNEL_SIZE_WIDTH each  kernel position of this cycle
- weight_addr  out  WADDR_WIDTH  row-major kernel index krow·k+kcol
- conv_result_ready  in  1  datapath result strobe
- conv_result  in  PARA_X·PARA_Y·DATA_WIDTH  datapath result
- out_valid  out  1  result held for downstream
- out_ready  in  1  downstream accept
- out_data  out  PARA_X·PARA_Y·DATA_WIDTH  captured result
- out_tile  out  TILE_CNT_WIDTH  index of tile in out_data
- done  out  1  one-cycle pulse after last tile accepted
- err_timeout  out  1  sticky watchdog flag (see Configuration)

## Operation
- Reset values: busy 0, err_ksize 0, conv_rst_n 0, fetch_valid 0, fetch_type 0, fetch_krow/kcol 0, weight_addr 0, out_valid 0, out_data 0, out_tile 0, done 0, err_timeout 0; state IDLE.
- IDLE: conv_rst_n 0. On start with kernel_size ∈ {3,5}: latch k and num_tiles, clear tile index, go to FEED. Otherwise pulse err_ksize and stay in IDLE.
- FEED: conv_rst_n 1 and fetch_valid 1 for exactly k² cycles. Counters krow/kcol advance kcol-first.
- fetch_type per step c (c = krow·k + kcol):
  - c=0 → 0
  - c%k=0 → 2
  - 0<c<k → 1
  - else → 3
- After the last step (krow=kcol=k−1), go to WAIT.
- WAIT: conv_rst_n 1, fetch_valid 0. When conv_result_ready is high, capture conv_result into out_data and the tile index into out_tile, set out_valid, drop conv_rst_n to 0, and go to HOLD.
- HOLD: out_valid held, out_data stable until out_ready is high. On acceptance:
  - if tile index = num_tiles−1: pulse done, go to IDLE.
  - else: increment the tile index, go to FEED. conv_rst_n was low for at least one cycle.
- start while busy: ignored. out_ready outside HOLD: ignored.
- rst mid-job: synchronous abort to IDLE with reset values. A held result is discarded.

## Timing
- Start sampled at cycle T → FEED during T+1..T+k². fetch_valid is high on exactly k² cycles; conv_rst_n rises at T+1.
- conv_result_ready in WAIT at cycle W → out_valid from W+1.
- Result strobe arriving in the same cycle as the last FEED step is ignored; it is only honoured in WAIT.
- out_valid and out_ready both high at cycle H → the next tile's FEED begins at H+2. The intervening cycle keeps conv_rst_n low. done pulses at H+1 for the last tile.
- Minimum per-tile period: k²+1 feed/wait cycles plus datapath latency plus 2.

## Configuration
- CONV_SCHED_TIMEOUT_EN defined:
  - a 7-bit counter runs in WAIT; reaching 64 cycles without conv_result_ready sets err_timeout (sticky until rst) and forces IDLE with conv_rst_n 0.
- Undefined: no counter; WAIT waits indefinitely and err_timeout is tied 0.

## Structure
- Shared package `conv_pkg`:
  - state enum (IDLE, FEED, WAIT, HOLD)
  - fetch_type encodings
  - KERNEL_SIZE_MAX=5
  - timeout limit constant
- Sub-module `conv_kernel_walker`: krow/kcol counter with wrap at k, fetch_type decode and weight_addr generation. The FSM stays in the top.

## Test plan
- Reset: rst high 2 cycles, then low → all outputs at reset values; start with k=3, num_tiles=1 → 9 fetch cycles, types 0,1,1,2,3,3,2,3,3, weight_addr 0..8.
- k=5, num_tiles=2, out_ready always 1 → 25 fetch cycles per tile; out_tile 0 then 1; done pulses once after tile 1.
- out_ready held 0 for 10 cycles in HOLD → out_valid and out_data stable, and no fetch_valid during that time.
- start with kernel_size=4 → err_ksize single pulse, busy stays 0. start pulsed during FEED → ignored.
- rst asserted on FEED step 5 → next cycle IDLE, conv_rst_n 0, fetch_valid 0.
- With CONV_SCHED_TIMEOUT_EN, no conv_result_ready → err_timeout set 64 cycles after WAIT entry, state IDLE.
